// File: rtl/etapa_id_ex.sv
// etapa_id_ex: ID/EX pipeline register with write-back bypass, load-use stall, flush and bubble counter
module etapa_id_ex #(
    parameter int ANCHO     = 32,
    parameter int ANCHO_CNT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valido_id,
    input  logic [ANCHO-1:0]     pc4_id,
    input  logic [ANCHO-1:0]     datolec1,
    input  logic [ANCHO-1:0]     datolec2,
    input  logic [4:0]           dirlec1,
    input  logic [4:0]           dirlec2,
    input  logic [4:0]           rd_id,
    input  logic [15:0]          inm_id,
    input  logic                 regdst_id,
    input  logic                 alusrc_id,
    input  logic                 memrd_id,
    input  logic                 memwr_id,
    input  logic                 memtoreg_id,
    input  logic                 enesc_id,
    input  logic [2:0]           aluop_id,
    input  logic [4:0]           diresc,
    input  logic [ANCHO-1:0]     datoesc,
    input  logic                 enesc,
    input  logic                 flush,
    output logic                 stall,
    output logic                 valido_ex,
    output logic [ANCHO-1:0]     pc4_ex,
    output logic [ANCHO-1:0]     op1_ex,
    output logic [ANCHO-1:0]     op2_ex,
    output logic [ANCHO-1:0]     inm_ex,
    output logic [4:0]           rt_ex,
    output logic [4:0]           rs_ex,
    output logic [4:0]           direx,
    output logic                 regdst_ex,
    output logic                 alusrc_ex,
    output logic [2:0]           aluop_ex,
    output logic                 memrd_ex,
    output logic                 memwr_ex,
    output logic                 memtoreg_ex,
    output logic                 enesc_ex,
    output logic [ANCHO_CNT-1:0] cnt_burbujas
);
    logic                 valido_q, valido_d;
    logic [ANCHO-1:0]     pc4_q, pc4_d, op1_q, op1_d, op2_q, op2_d, inm_q, inm_d;
    logic [4:0]           rt_q, rt_d, rs_q, rs_d, dir_q, dir_d;
    logic                 regdst_q, regdst_d, alusrc_q, alusrc_d;
    logic [2:0]           aluop_q, aluop_d;
    logic                 memrd_q, memrd_d, memwr_q, memwr_d, memtoreg_q, memtoreg_d, enesc_q, enesc_d;
    logic [ANCHO_CNT-1:0] cnt_q, cnt_d;
    logic                 burbuja;

    assign stall = valido_id & memrd_q & valido_q & (rt_q != 5'd0) &
                   ((rt_q == dirlec1) | (rt_q == dirlec2));
    assign burbuja = flush | stall;

    // Next EX contents: data always follows ID, control is killed on a bubble
    always_comb begin
        pc4_d      = pc4_id;
        op1_d      = (enesc && diresc != 5'd0 && diresc == dirlec1) ? datoesc : datolec1;
        op2_d      = (enesc && diresc != 5'd0 && diresc == dirlec2) ? datoesc : datolec2;
        inm_d      = {{(ANCHO-16){inm_id[15]}}, inm_id};
        rt_d       = dirlec2;
        rs_d       = dirlec1;
        dir_d      = regdst_id ? rd_id : dirlec2;
        regdst_d   = regdst_id;
        alusrc_d   = alusrc_id;
        aluop_d    = aluop_id;
        valido_d   = valido_id & ~burbuja;
        memrd_d    = memrd_id & ~burbuja;
        memwr_d    = memwr_id & ~burbuja;
        memtoreg_d = memtoreg_id & ~burbuja;
        enesc_d    = enesc_id & ~burbuja;
        cnt_d      = (burbuja && valido_id && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // EX register bank and bubble counter, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valido_q   <= 1'b0;
            pc4_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            inm_q      <= '0;
            rt_q       <= '0;
            rs_q       <= '0;
            dir_q      <= '0;
            regdst_q   <= 1'b0;
            alusrc_q   <= 1'b0;
            aluop_q    <= '0;
            memrd_q    <= 1'b0;
            memwr_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            enesc_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            valido_q   <= valido_d;
            pc4_q      <= pc4_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            inm_q      <= inm_d;
            rt_q       <= rt_d;
            rs_q       <= rs_d;
            dir_q      <= dir_d;
            regdst_q   <= regdst_d;
            alusrc_q   <= alusrc_d;
            aluop_q    <= aluop_d;
            memrd_q    <= memrd_d;
            memwr_q    <= memwr_d;
            memtoreg_q <= memtoreg_d;
            enesc_q    <= enesc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign valido_ex    = valido_q;
    assign pc4_ex       = pc4_q;
    assign op1_ex       = op1_q;
    assign op2_ex       = op2_q;
    assign inm_ex       = inm_q;
    assign rt_ex        = rt_q;
    assign rs_ex        = rs_q;
    assign direx        = dir_q;
    assign regdst_ex    = regdst_q;
    assign alusrc_ex    = alusrc_q;
    assign aluop_ex     = aluop_q;
    assign memrd_ex     = memrd_q;
    assign memwr_ex     = memwr_q;
    assign memtoreg_ex  = memtoreg_q;
    assign enesc_ex     = enesc_q;
    assign cnt_burbujas = cnt_q;
endmodule

// File: doc/etapa_id_ex.md
Name: etapa_id_ex

Overview:
- ID/EX pipeline register of the MIPS datapath, directly downstream of the register file.
- Captures the two register-file read operands, the sign-extended immediate, register addresses and decode control bits at each clock edge.
- Forwards a same-cycle write-back value into the captured operands, detects load-use hazards (stalling ID and inserting a bubble), honours a branch flush and counts inserted bubbles.

Parameters:
- ANCHO, 32, datapath width of operands and PC+4.
- ANCHO_CNT, 16, width of the saturating bubble counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- valido_id  input  1  ID holds a real instruction.
- pc4_id  input  ANCHO  PC+4 of the ID instruction.
- datolec1  input  ANCHO  register-file read port 1 (rs value).
- datolec2  input  ANCHO  register-file read port 2 (rt value).
- dirlec1  input  5  rs address.
- dirlec2  input  5  rt address.
- rd_id  input  5  rd field.
- inm_id  input  16  immediate field.
- regdst_id, alusrc_id, memrd_id, memwr_id, memtoreg_id, enesc_id  input  1 each  decode control bits.
- aluop_id  input  3  ALU operation.
- diresc  input  5  write-back address (same net as the register-file write address).
- datoesc  input  ANCHO  write-back data.
- enesc  input  1  write-back enable.
- flush  input  1  branch taken; kill the ID instruction.
- stall  output  1  combinational; hold PC and IF/ID this cycle.
- valido_ex, pc4_ex, op1_ex, op2_ex, inm_ex (ANCHO, sign-extended), rt_ex (5), rs_ex (5), direx (5), regdst_ex, alusrc_ex, aluop_ex (3), memrd_ex, memwr_ex, memtoreg_ex, enesc_ex  output  registered EX-stage copies.
- cnt_burbujas  output  ANCHO_CNT  saturating count of inserted bubbles.

Behaviour:
- Reset: all registered outputs are 0 and cnt_burbujas is 0 on the first edge with rst_n=0. stall is therefore 0 after reset. Reset overrides flush and stall.
- Hazard: stall = valido_id & memrd_ex & valido_ex & (rt_ex != 0) & ((rt_ex == dirlec1) | (rt_ex == dirlec2)).
- Each edge, priority is reset > flush > stall > load.
- Bubble (flush=1 or stall=1):
  - valido_ex, memrd_ex, memwr_ex, enesc_ex, memtoreg_ex are cleared to 0.
  - Data and address fields may take any value; the bench checks them only when valido_ex=1.
  - cnt_burbujas increments by 1 unless it equals all ones (saturates, no wrap).
  - A flush coinciding with a stall counts once.
  - A flush with valido_id=0 still inserts a bubble but does not increment the counter.
- Load (otherwise): all fields are copied from the ID inputs with latency 1 cycle, and valido_ex = valido_id.
  - direx = regdst_id ? rd_id : dirlec2.
  - inm_ex = {{ANCHO-16{inm_id[15]}}, inm_id}.
- Write-back bypass on load:
  - op1_ex = datoesc if enesc & (diresc != 0) & (diresc == dirlec1), else datolec1.
  - op2_ex uses the same rule with dirlec2.
  - Both operands may bypass in the same cycle. Address 0 is never bypassed.
- The stall lasts exactly one cycle per load-use pair. The next cycle has a bubble in EX (memrd_ex=0), so the held ID instruction loads normally.
- No internal state beyond the EX registers and the counter.
- rst_n deasserted mid-stall: the next edge loads normally (EX is empty).

Test Plan:
- Reset: rst_n=0 for 2 cycles with arbitrary inputs -> all outputs 0, stall=0, cnt_burbujas=0.
- Normal load:
  - Stimulus: valido_id=1, datolec1=0x11, datolec2=0x22, inm_id=0x8001, regdst_id=1, rd_id=7.
  - Required after 1 edge: op1_ex=0x11, op2_ex=0x22, inm_ex=0xFFFF8001, direx=7.
  - Repeat with regdst_id=0, dirlec2=5 -> direx=5.
- Bypass:
  - enesc=1, diresc=3, datoesc=0xABCD, dirlec1=dirlec2=3, datolec1=datolec2=0 -> op1_ex=op2_ex=0xABCD.
  - Repeat with diresc=dirlec1=0 -> op1_ex=datolec1.
- Load-use:
  - Stimulus: EX holds lw with rt_ex=4 (memrd_ex=1, valido_ex=1); ID has dirlec2=4.
  - Required: stall=1; next edge valido_ex=0, memwr_ex=0, enesc_ex=0, cnt_burbujas=1.
  - The following cycle: stall=0 and the held instruction loads.
  - Repeat with rt_ex=0 -> stall=0.
- Flush during stall: flush=1 while stall=1 -> one bubble, cnt_burbujas +1 only.
- Saturation: ANCHO_CNT=2 with 5 consecutive flushes (valido_id=1) -> cnt_burbujas holds at 3.
